// File: rtl/store_seq_pkg.sv
// Shared encodings for the store read-modify-write sequencer: store sizes, FSM states
// and the alignment rule.
package store_seq_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Illegal size, or a half/word store not aligned to its own width.
  function automatic logic is_illegal(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_WORD: is_illegal = (off != 2'b00);
      SZ_HALF: is_illegal = off[0];
      SZ_BYTE: is_illegal = 1'b0;
      default: is_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge: replaces the byte or half selected by the
// offset inside the old memory word with the new store data.
module store_lane_merge
  import store_seq_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] new_data,
  input  size_e       size,
  input  logic [1:0]  offset,
  output logic [31:0] word
);

  always_comb begin
    word = old_word;
    case (size)
      SZ_BYTE: word[{offset, 3'b000} +: 8] = new_data[7:0];
      SZ_HALF: begin
        if (offset[1]) word[31:16] = new_data;
        else           word[15:0]  = new_data;
      end
      default: word = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Multicycle SW/SH/SB store sequencer; half and byte stores read-modify-write the aligned
// word. Optional mem_ready timeout enabled by defining STORE_SEQ_TIMEOUT_EN.
module store_rmw_sequencer
  import store_seq_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  state_e      state, state_nxt;
  logic        err_nxt;
  size_e       size_in, size_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] merged;
  logic        timed_out;

  assign size_in = size_e'(size);

`ifdef STORE_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts cycles already spent in the current request state; restarts on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if ((state_nxt == state) && (state == ST_READ || state == ST_WRITE)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timed_out = !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_illegal(size_in, addr[1:0])) begin
            state_nxt = ST_DONE;
            err_nxt   = 1'b1;
          end else if (size_in == SZ_WORD) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (mem_ready) begin
          state_nxt = ST_MERGE;
        end else if (timed_out) begin
          state_nxt = ST_DONE;
          err_nxt   = 1'b1;
        end
      end
      ST_MERGE: state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (mem_ready) begin
          state_nxt = ST_DONE;
        end else if (timed_out) begin
          state_nxt = ST_DONE;
          err_nxt   = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so requests drop the cycle after mem_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
    end else begin
      busy   <= (state_nxt != ST_IDLE);
      done   <= (state_nxt == ST_DONE);
      err    <= err_nxt;
      mem_rd <= (state_nxt == ST_READ);
      mem_wr <= (state_nxt == ST_WRITE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      size_q    <= SZ_WORD;
      off_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        mem_addr <= {addr[ADDR_W-1:2], 2'b00};
        size_q   <= size_in;
        off_q    <= addr[1:0];
        wdata_q  <= wdata[15:0];
        if (size_in == SZ_WORD) mem_wdata <= wdata;
      end
      if (state == ST_READ && mem_ready) rdata_q <= mem_rdata;
      if (state == ST_MERGE) mem_wdata <= merged;
    end
  end

  store_lane_merge u_merge (
    .old_word (rdata_q),
    .new_data (wdata_q),
    .size     (size_q),
    .offset   (off_q),
    .word     (merged)
  );

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Self-checking bench for store_rmw_sequencer: directed scenarios plus randomized stores
// against a byte-lane reference model with a responsive memory stub.
module tb_store_rmw_sequencer;

`ifdef STORE_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int unsigned TO_CYC = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  store_rmw_sequencer #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Observations collected by run_store
  int          obs_done_cyc, obs_wr_cyc, obs_rcnt;
  bit          obs_err, obs_rd, obs_wr, v_both, v_stable, v_busy;
  bit          obs_after_done, obs_after_busy;
  logic [31:0] obs_rd_addr, obs_wr_addr, obs_wr_data;

  // Model outputs
  int          exp_done_cyc;
  bit          exp_err, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_data;

  // Reference model: latency, error and final word from the store rules.
  task automatic model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int unsigned rdly, input int unsigned wdly);
    logic [7:0] b [4];
    int off;
    bit ill;
    off      = int'(a[1:0]);
    exp_addr = {a[31:2], 2'b00};
    ill = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd0 && off != 0);
    exp_err = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_data = wd;
    if (ill) begin
      exp_done_cyc = 1; exp_err = 1'b1;
    end else if (sz == 2'd0) begin
      exp_wr = 1'b1;
      if (TO_EN && wdly >= TO_CYC) begin exp_done_cyc = 1 + TO_CYC; exp_err = 1'b1; end
      else exp_done_cyc = 2 + int'(wdly);
    end else begin
      exp_rd = 1'b1;
      for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
      b[off] = wd[7:0];
      if (sz == 2'd1) b[off+1] = wd[15:8];
      exp_data = {b[3], b[2], b[1], b[0]};
      if (TO_EN && rdly >= TO_CYC) begin
        exp_done_cyc = 1 + TO_CYC; exp_err = 1'b1;
      end else begin
        exp_wr = 1'b1;
        if (TO_EN && wdly >= TO_CYC) begin exp_done_cyc = 3 + int'(rdly) + TO_CYC; exp_err = 1'b1; end
        else exp_done_cyc = 4 + int'(rdly) + int'(wdly);
      end
    end
  endtask

  // Issues one store (start in cycle 0) and plays memory: ready on request cycle dly+1.
  task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int unsigned rdly, input int unsigned wdly,
                           input bit noise);
    int unsigned rc, wc;
    rc = 0; wc = 0;
    obs_done_cyc = -1; obs_wr_cyc = -1; obs_rcnt = 0; obs_err = 1'b0;
    obs_rd = 1'b0; obs_wr = 1'b0; v_both = 1'b0; v_stable = 1'b0; v_busy = 1'b0;
    obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
    obs_after_done = 1'b1; obs_after_busy = 1'b1;
    @(negedge clk);
    start = 1'b1; size = sz; addr = a; wdata = wd; mem_ready = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      start = noise; size = 2'($urandom); addr = $urandom; wdata = $urandom;
      if (mem_rd && mem_wr) v_both = 1'b1;
      if (!busy) v_busy = 1'b1;
      if (mem_rd) begin
        if (!obs_rd) obs_rd_addr = mem_addr;
        else if (mem_addr !== obs_rd_addr) v_stable = 1'b1;
        obs_rd = 1'b1; rc++;
      end
      if (mem_wr) begin
        if (!obs_wr) begin obs_wr_addr = mem_addr; obs_wr_data = mem_wdata; obs_wr_cyc = c; end
        else if (mem_addr !== obs_wr_addr || mem_wdata !== obs_wr_data) v_stable = 1'b1;
        obs_wr = 1'b1; wc++;
      end
      if (mem_rd)      mem_ready = (rc > rdly);
      else if (mem_wr) mem_ready = (wc > wdly);
      else             mem_ready = 1'($urandom);
      mem_rdata = (mem_rd && mem_ready) ? rd : $urandom;
      if (done) begin
        obs_done_cyc = c; obs_err = err;
        break;
      end
    end
    obs_rcnt = int'(rc);
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b0;
    obs_after_done = done; obs_after_busy = busy;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, err, mem_rd, mem_wr} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mem_rd, mem_wr}); end
    checks++; if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h want 00000000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_wdata: got %h want 00000000", mem_wdata); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_sw;
    run_store(2'd0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    checks++; if (obs_rd !== 1'b0) begin errors++; $display("FAIL sw_no_read: got %b want 0", obs_rd); end
    checks++; if (obs_wr_cyc != 1) begin errors++; $display("FAIL sw_wr_cycle: got %0d want 1", obs_wr_cyc); end
    checks++; if (obs_wr_addr !== 32'h100 || obs_wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_write: got %h/%h want 00000100/deadbeef", obs_wr_addr, obs_wr_data); end
    checks++; if (obs_done_cyc != 2 || obs_err !== 1'b0) begin
      errors++; $display("FAIL sw_done: got cyc %0d err %b want cyc 2 err 0", obs_done_cyc, obs_err); end
    checks++; if (obs_after_done !== 1'b0 || obs_after_busy !== 1'b0) begin
      errors++; $display("FAIL sw_one_pulse: got done %b busy %b want 0 0", obs_after_done, obs_after_busy); end
  endtask

  task automatic test_sb;
    run_store(2'd2, 32'h103, 32'h000000AB, 32'h11223344, 0, 0, 1'b0);
    checks++; if (obs_rd_addr !== 32'h100) begin
      errors++; $display("FAIL sb_rd_addr: got %h want 00000100", obs_rd_addr); end
    checks++; if (obs_wr_data !== 32'hAB223344) begin
      errors++; $display("FAIL sb_merge: got %h want ab223344", obs_wr_data); end
    checks++; if (obs_done_cyc != 4 || obs_err !== 1'b0) begin
      errors++; $display("FAIL sb_done: got cyc %0d err %b want cyc 4 err 0", obs_done_cyc, obs_err); end
  endtask

  task automatic test_sh_wait;
    run_store(2'd1, 32'h102, 32'h0000CAFE, 32'h11223344, 2, 2, 1'b0);
    checks++; if (obs_wr_data !== 32'hCAFE3344) begin
      errors++; $display("FAIL sh_merge: got %h want cafe3344", obs_wr_data); end
    checks++; if (obs_rcnt != 3) begin errors++; $display("FAIL sh_rd_hold: got %0d want 3", obs_rcnt); end
    checks++; if (v_stable || v_both) begin
      errors++; $display("FAIL sh_stable: got unstable %b both %b want 0 0", v_stable, v_both); end
    checks++; if (obs_done_cyc != 8) begin errors++; $display("FAIL sh_done: got %0d want 8", obs_done_cyc); end
  endtask

  task automatic test_illegal;
    logic [1:0]  szs [2] = '{2'd1, 2'd3};
    logic [31:0] as  [2] = '{32'h101, 32'h100};
    for (int i = 0; i < 2; i++) begin
      run_store(szs[i], as[i], 32'h12345678, 32'h0, 0, 0, 1'b0);
      checks++; if (obs_done_cyc != 1 || obs_err !== 1'b1) begin
        errors++; $display("FAIL illegal_done[%0d]: got cyc %0d err %b want cyc 1 err 1", i, obs_done_cyc, obs_err); end
      checks++; if (obs_rd || obs_wr) begin
        errors++; $display("FAIL illegal_noaccess[%0d]: got rd %b wr %b want 0 0", i, obs_rd, obs_wr); end
    end
  endtask

  task automatic test_timeout;
    run_store(2'd2, 32'h40, 32'h55, 32'h0, 1000, 0, 1'b0);
    checks++; if (obs_rcnt != int'(TO_CYC) || obs_wr) begin
      errors++; $display("FAIL to_read_drop: got rd cycles %0d wr %b want %0d 0", obs_rcnt, obs_wr, TO_CYC); end
    checks++; if (obs_done_cyc != 17 || obs_err !== 1'b1) begin
      errors++; $display("FAIL to_done: got cyc %0d err %b want cyc 17 err 1", obs_done_cyc, obs_err); end
    run_store(2'd0, 32'h44, 32'h01020304, 32'h0, 0, 0, 1'b0);
    checks++; if (obs_done_cyc != 2 || obs_err !== 1'b0 || obs_wr_data !== 32'h01020304) begin
      errors++; $display("FAIL to_recover: got cyc %0d err %b data %h want 2 0 01020304", obs_done_cyc, obs_err, obs_wr_data); end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; size = 2'd0; addr = 32'h200; wdata = 32'hA5A5A5A5; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; addr = 32'h300;
    checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL rst_mid_write: got wr %b addr %h want 1 00000200", mem_wr, mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got wr %b busy %b want 0 0", mem_wr, busy); end
    start = 1'b0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done) saw_done = 1'b1; end
    checks++; if (saw_done) begin errors++; $display("FAIL rst_mid_nodone: got done 1 want 0"); end
    run_store(2'd2, 32'h201, 32'h77, 32'hFFFFFFFF, 1, 0, 1'b1);
    checks++; if (obs_wr_data !== 32'hFFFF77FF || obs_wr_addr !== 32'h200) begin
      errors++; $display("FAIL busy_start_ignored: got %h@%h want ffff77ff@00000200", obs_wr_data, obs_wr_addr); end
    checks++; if (obs_after_busy !== 1'b0 || obs_done_cyc != 5) begin
      errors++; $display("FAIL done_start_ignored: got busy %b cyc %0d want 0 5", obs_after_busy, obs_done_cyc); end
  endtask

  task automatic test_random;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd;
    int unsigned rdly, wdly;
    bit noise;
    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3)); a = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (sz == 2'd0) ? 2'b00 : (sz == 2'd1) ? {a[1], 1'b0} : a[1:0];
      rdly = $urandom_range(0, 3); wdly = $urandom_range(0, 3); noise = 1'($urandom);
      run_store(sz, a, wd, rd, rdly, wdly, noise);
      model(sz, a, wd, rd, rdly, wdly);
      checks++; if (obs_done_cyc != exp_done_cyc || obs_err !== exp_err) begin
        errors++; $display("FAIL rnd_done[%0d]: got cyc %0d err %b want cyc %0d err %b", n, obs_done_cyc, obs_err, exp_done_cyc, exp_err); end
      checks++; if (obs_rd !== exp_rd || obs_wr !== exp_wr) begin
        errors++; $display("FAIL rnd_access[%0d]: got rd %b wr %b want %b %b", n, obs_rd, obs_wr, exp_rd, exp_wr); end
      if (exp_rd) begin
        checks++; if (obs_rd_addr !== exp_addr) begin
          errors++; $display("FAIL rnd_rd_addr[%0d]: got %h want %h", n, obs_rd_addr, exp_addr); end
      end
      if (exp_wr) begin
        checks++; if (obs_wr_addr !== exp_addr || obs_wr_data !== exp_data) begin
          errors++; $display("FAIL rnd_write[%0d]: got %h@%h want %h@%h", n, obs_wr_data, obs_wr_addr, exp_data, exp_addr); end
      end
      checks++; if (v_both || v_stable || v_busy || obs_after_done || obs_after_busy) begin
        errors++; $display("FAIL rnd_protocol[%0d]: got both %b stable %b busy %b pulse %b idle %b want 0 0 0 0 0",
                           n, v_both, v_stable, v_busy, obs_after_done, obs_after_busy); end
    end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_sb;
    test_sh_wait;
    test_illegal;
    if (TO_EN) test_timeout;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
